// File: rtl/move_list_reader_pkg.sv
`default_nettype none
// ============================================================================
// Package  : move_list_reader_pkg
// Brief    : Shared board constants and UCI move-word layout for the move reader.
// Revision : 1.0 - initial release
// ============================================================================
package move_list_reader_pkg;

    localparam int MAX_POSITIONS = 256;

    // UCI word layout: {promotion[3:0], to[5:0], from[5:0]}
    localparam int UCI_FROM_LSB  = 0;
    localparam int UCI_TO_LSB    = 6;
    localparam int UCI_PROMO_LSB = 12;
    localparam int UCI_SQ_BITS   = 6;
    localparam int UCI_PROMO_BITS = 4;
    localparam int UCI_BITS      = UCI_PROMO_LSB + UCI_PROMO_BITS;

    typedef enum logic [3:0] {
        PIECE_EMPTY  = 4'd0,
        PIECE_PAWN   = 4'd1,
        PIECE_KNIGHT = 4'd2,
        PIECE_BISHOP = 4'd3,
        PIECE_ROOK   = 4'd4,
        PIECE_QUEEN  = 4'd5,
        PIECE_KING   = 4'd6
    } piece_t;

endpackage
`default_nettype wire

// File: rtl/move_list_reader.sv
`default_nettype none
// ============================================================================
// Module   : move_list_reader
// Brief    : Streams a completed all_moves table out as a valid/ready sequence.
// Revision : 1.0 - initial release
// ============================================================================
module move_list_reader
    import move_list_reader_pkg::*;
#(
    parameter int MAX_POSITIONS_LOG2 = $clog2(MAX_POSITIONS),
    parameter int EVAL_WIDTH         = 24,
    parameter int UCI_WIDTH          = UCI_BITS,
    parameter int RD_LATENCY         = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          am_moves_ready,
    input  logic [MAX_POSITIONS_LOG2-1:0] am_move_count,
    input  logic                          initial_mate,
    input  logic                          initial_stalemate,
    input  logic [UCI_WIDTH-1:0]          uci_in,
    input  logic [EVAL_WIDTH-1:0]         eval_in,
    input  logic                          capture_in,
    input  logic                          abort,
    output logic [MAX_POSITIONS_LOG2-1:0] am_move_index,
    output logic                          am_clear_moves,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [UCI_WIDTH-1:0]          m_uci,
    output logic [EVAL_WIDTH-1:0]         m_eval,
    output logic                          m_capture,
    output logic [MAX_POSITIONS_LOG2-1:0] m_index,
    output logic                          m_last,
    output logic                          list_done,
    output logic [1:0]                    done_status,
    output logic                          busy
);

    localparam int IW = MAX_POSITIONS_LOG2;
    localparam logic [2:0]    c_RD_LAT  = 3'(RD_LATENCY);
    localparam logic [IW-1:0] c_IDX_ONE = IW'(1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT       = 3'd1,
        ST_PRESENT    = 3'd2,
        ST_CLEAR      = 3'd3,
        ST_CLEAR_WAIT = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            wait_q, wait_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [IW-1:0]         count_q, count_d;
    logic                  valid_q, valid_d;
    logic [UCI_WIDTH-1:0]  uci_q, uci_d;
    logic [EVAL_WIDTH-1:0] eval_q, eval_d;
    logic                  cap_q, cap_d;
    logic [IW-1:0]         mindex_q, mindex_d;
    logic                  last_q, last_d;
    logic                  clear_q, clear_d;
    logic                  done_q, done_d;
    logic [1:0]            status_q, status_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wait_q   <= '0;
            idx_q    <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            uci_q    <= '0;
            eval_q   <= '0;
            cap_q    <= 1'b0;
            mindex_q <= '0;
            last_q   <= 1'b0;
            clear_q  <= 1'b0;
            done_q   <= 1'b0;
            status_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            uci_q    <= uci_d;
            eval_q   <= eval_d;
            cap_q    <= cap_d;
            mindex_q <= mindex_d;
            last_q   <= last_d;
            clear_q  <= clear_d;
            done_q   <= done_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        idx_d    = idx_q;
        count_d  = count_q;
        valid_d  = valid_q;
        uci_d    = uci_q;
        eval_d   = eval_q;
        cap_d    = cap_q;
        mindex_d = mindex_q;
        last_d   = last_q;
        clear_d  = 1'b0;
        done_d   = 1'b0;
        status_d = status_q;

        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (am_moves_ready) begin
                    count_d = am_move_count;
                    if (am_move_count == '0) begin
                        status_d = {initial_mate, initial_stalemate};
                        state_d  = ST_CLEAR;
                    end else begin
                        status_d = 2'b00;
                        wait_d   = c_RD_LAT;
                        state_d  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    valid_d = 1'b0;
                    state_d = ST_CLEAR;
                end else begin
                    wait_d = wait_q - 3'd1;
                    // Table data for idx_q is valid in the cycle the counter expires.
                    if (wait_q == 3'd1) begin
                        uci_d    = uci_in;
                        eval_d   = eval_in;
                        cap_d    = capture_in;
                        mindex_d = idx_q;
                        last_d   = (idx_q == count_q - c_IDX_ONE);
                        valid_d  = 1'b1;
                        state_d  = ST_PRESENT;
                    end
                end
            end
            ST_PRESENT: begin
                if (abort) begin
                    valid_d = 1'b0;
                    state_d = ST_CLEAR;
                end else if (m_ready) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        state_d = ST_CLEAR;
                    end else begin
                        idx_d   = idx_q + c_IDX_ONE;
                        wait_d  = c_RD_LAT;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_CLEAR: begin
                clear_d = 1'b1;
                done_d  = 1'b1;
                idx_d   = '0;
                state_d = ST_CLEAR_WAIT;
            end
            ST_CLEAR_WAIT: begin
                // Gives all_moves a cycle to drop its ready flag after the clear.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign am_move_index  = idx_q;
    assign am_clear_moves = clear_q;
    assign m_valid        = valid_q;
    assign m_uci          = uci_q;
    assign m_eval         = eval_q;
    assign m_capture      = cap_q;
    assign m_index        = mindex_q;
    assign m_last         = last_q;
    assign list_done      = done_q;
    assign done_status    = status_q;
    assign busy           = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_move_list_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_list_reader
// Brief    : Self-checking bench for move_list_reader against a move-table model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_move_list_reader;
    import move_list_reader_pkg::*;

    localparam int IW  = $clog2(MAX_POSITIONS);
    localparam int EW  = 24;
    localparam int UW  = UCI_BITS;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, am_moves_ready, initial_mate, initial_stalemate, abort, m_ready;
    logic [IW-1:0] am_move_count;
    logic [UW-1:0] uci_in;
    logic [EW-1:0] eval_in;
    logic          capture_in;
    logic [IW-1:0] am_move_index, m_index;
    logic          am_clear_moves, m_valid, m_capture, m_last, list_done, busy;
    logic [UW-1:0] m_uci;
    logic [EW-1:0] m_eval;
    logic [1:0]    done_status;

    logic          lat_go;
    logic [IW-1:0] lat_count;
    logic [IW-1:0] l1_idx, l1_mindex, l3_idx, l3_mindex;
    logic          l1_clr, l1_valid, l1_cap, l1_last, l1_done, l1_busy;
    logic          l3_clr, l3_valid, l3_cap, l3_last, l3_done, l3_busy;
    logic [UW-1:0] l1_uci, l3_uci;
    logic [EW-1:0] l1_eval, l3_eval;
    logic [1:0]    l1_status, l3_status;

    // Move table: an entry becomes readable RD_LATENCY cycles after its address.
    logic [UW-1:0] t_uci  [0:MAX_POSITIONS-1];
    logic [EW-1:0] t_eval [0:MAX_POSITIONS-1];
    logic          t_cap  [0:MAX_POSITIONS-1];
    logic [IW-1:0] h2, h3a, h3b;

    always @(posedge clk) begin
        h2  <= am_move_index;
        h3a <= l3_idx;
        h3b <= h3a;
    end

    assign uci_in     = t_uci[h2];
    assign eval_in    = t_eval[h2];
    assign capture_in = t_cap[h2];

    move_list_reader #(.EVAL_WIDTH(EW), .UCI_WIDTH(UW), .RD_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .am_moves_ready(am_moves_ready), .am_move_count(am_move_count),
        .initial_mate(initial_mate), .initial_stalemate(initial_stalemate),
        .uci_in(uci_in), .eval_in(eval_in), .capture_in(capture_in), .abort(abort),
        .am_move_index(am_move_index), .am_clear_moves(am_clear_moves), .m_valid(m_valid),
        .m_ready(m_ready), .m_uci(m_uci), .m_eval(m_eval), .m_capture(m_capture),
        .m_index(m_index), .m_last(m_last), .list_done(list_done),
        .done_status(done_status), .busy(busy)
    );

    move_list_reader #(.EVAL_WIDTH(EW), .UCI_WIDTH(UW), .RD_LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset), .am_moves_ready(lat_go), .am_move_count(lat_count),
        .initial_mate(1'b0), .initial_stalemate(1'b0),
        .uci_in(t_uci[l1_idx]), .eval_in(t_eval[l1_idx]), .capture_in(t_cap[l1_idx]), .abort(1'b0),
        .am_move_index(l1_idx), .am_clear_moves(l1_clr), .m_valid(l1_valid),
        .m_ready(1'b1), .m_uci(l1_uci), .m_eval(l1_eval), .m_capture(l1_cap),
        .m_index(l1_mindex), .m_last(l1_last), .list_done(l1_done),
        .done_status(l1_status), .busy(l1_busy)
    );

    move_list_reader #(.EVAL_WIDTH(EW), .UCI_WIDTH(UW), .RD_LATENCY(3)) dut_l3 (
        .clk(clk), .reset(reset), .am_moves_ready(lat_go), .am_move_count(lat_count),
        .initial_mate(1'b0), .initial_stalemate(1'b0),
        .uci_in(t_uci[h3b]), .eval_in(t_eval[h3b]), .capture_in(t_cap[h3b]), .abort(1'b0),
        .am_move_index(l3_idx), .am_clear_moves(l3_clr), .m_valid(l3_valid),
        .m_ready(1'b1), .m_uci(l3_uci), .m_eval(l3_eval), .m_capture(l3_cap),
        .m_index(l3_mindex), .m_last(l3_last), .list_done(l3_done),
        .done_status(l3_status), .busy(l3_busy)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_table();
        for (int i = 0; i < MAX_POSITIONS; i++) begin
            t_uci[i]  = UW'($urandom);
            t_eval[i] = EW'($urandom);
            t_cap[i]  = 1'($urandom);
        end
    endtask

    // Expected behaviour: moves 0..cnt-1 (or up to abort_idx) in table order,
    // first one LAT cycles after acceptance, each next LAT+1 after a handshake,
    // then a single clear/list_done pulse two cycles after the last handshake.
    task automatic run_list(input string name, input int cnt, input logic mate, input logic stale,
                            input int stall_idx, input int stall_len, input int abort_idx);
        int  exp_idx    = 0;
        int  stall_left = stall_len;
        int  since      = 0;
        int  exp_gap    = LAT;
        int  cyc        = 0;
        int  n_exp      = (abort_idx >= 0 && abort_idx < cnt) ? abort_idx : cnt;
        bit  aborted    = 0;
        bit  showing    = 0;
        bit  pulse_seen = 0;
        bit  ended      = 0;

        fill_table();
        am_move_count     = IW'(cnt);
        initial_mate      = mate;
        initial_stalemate = stale;
        m_ready           = 1'b1;
        abort             = 1'b0;
        am_moves_ready    = 1'b1;
        tick();
        am_moves_ready = 1'b0;
        check({name, ":busy_accept"}, busy, 1'b1);
        check({name, ":status_accept"}, done_status, (cnt == 0) ? {mate, stale} : 2'b00);

        while (!ended && cyc < 600) begin
            abort = 1'b0;
            check({name, ":pulse_pair"}, list_done, am_clear_moves);

            if (aborted || exp_idx >= cnt) begin
                check({name, ":no_extra_valid"}, m_valid, 1'b0);
            end else if (m_valid) begin
                if (!showing) begin
                    check({name, ":gap"}, since, exp_gap);
                    showing = 1;
                end
                check({name, ":index"}, m_index, exp_idx);
                check({name, ":rd_addr"}, am_move_index, exp_idx);
                check({name, ":uci"}, m_uci, t_uci[exp_idx]);
                check({name, ":eval"}, m_eval, t_eval[exp_idx]);
                check({name, ":capture"}, m_capture, t_cap[exp_idx]);
                check({name, ":last"}, m_last, (exp_idx == cnt - 1));
                if (exp_idx == abort_idx) begin
                    abort   = 1'b1;
                    m_ready = 1'b1;
                    aborted = 1;
                    since   = 0;
                end else if (exp_idx == stall_idx && stall_left > 0) begin
                    m_ready = 1'b0;
                    stall_left--;
                end else begin
                    m_ready = 1'b1;
                    showing = 0;
                    exp_idx++;
                    since   = 0;
                    exp_gap = LAT + 1;
                end
            end else if (since > exp_gap) begin
                check({name, ":valid_timeout"}, m_valid, 1'b1);
                ended = 1;
            end

            if (pulse_seen) begin
                check({name, ":busy_end"}, busy, 1'b0);
                check({name, ":rd_addr_end"}, am_move_index, 0);
                ended = 1;
            end else if (am_clear_moves) begin
                pulse_seen = 1;
                check({name, ":clear_timing"}, since, (cnt == 0) ? 1 : 2);
                check({name, ":moves_before_clear"}, exp_idx, n_exp);
            end else if ((aborted || exp_idx >= cnt) && since > 2) begin
                check({name, ":clear_timeout"}, am_clear_moves, 1'b1);
                ended = 1;
            end

            if (!ended) begin
                tick();
                since++;
                cyc++;
            end
        end
        check({name, ":list_finished"}, ended, 1'b1);
    endtask

    initial begin
        int rcnt, rstall, rlen, rabort;
        int l1_rise[$];
        int l3_rise[$];
        int l1_pulses, l3_pulses;

        reset = 1'b1; am_moves_ready = 1'b0; am_move_count = '0; initial_mate = 1'b0;
        initial_stalemate = 1'b0; abort = 1'b0; m_ready = 1'b1; lat_go = 1'b0; lat_count = '0;
        fill_table();
        repeat (3) tick();
        check("por:m_valid", m_valid, 1'b0);
        check("por:busy", busy, 1'b0);
        check("por:rd_addr", am_move_index, 0);
        check("por:clear", am_clear_moves, 1'b0);
        check("por:list_done", list_done, 1'b0);
        check("por:status", done_status, 2'b00);
        check("por:m_uci", m_uci, 0);
        check("por:m_last", m_last, 1'b0);
        reset = 1'b0;
        tick();

        run_list("start20", 20, 1'b0, 1'b0, -1, 0, -1);
        run_list("stall3", 3, 1'b0, 1'b0, 1, 10, -1);
        run_list("mate0", 0, 1'b1, 1'b0, -1, 0, -1);
        check("mate0:status_held", done_status, 2'b10);
        run_list("stale0", 0, 1'b0, 1'b1, -1, 0, -1);
        check("stale0:status_held", done_status, 2'b01);
        run_list("abort30", 30, 1'b0, 1'b0, -1, 0, 5);

        for (int k = 0; k < 4; k++) begin
            rcnt   = $urandom_range(1, 12);
            rstall = $urandom_range(0, rcnt - 1);
            rlen   = $urandom_range(0, 6);
            rabort = ($urandom_range(0, 1) == 1) ? $urandom_range(0, rcnt - 1) : -1;
            run_list($sformatf("rand%0d", k), rcnt, 1'b0, 1'b0, rstall, rlen, rabort);
        end

        // Reset while waiting on the table: outputs return to reset values, no clear.
        fill_table();
        am_move_count  = IW'(10);
        am_moves_ready = 1'b1;
        tick();
        am_moves_ready = 1'b0;
        check("rst:busy_in_wait", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst:m_valid", m_valid, 1'b0);
        check("rst:m_uci", m_uci, 0);
        check("rst:m_eval", m_eval, 0);
        check("rst:m_capture", m_capture, 1'b0);
        check("rst:m_index", m_index, 0);
        check("rst:m_last", m_last, 1'b0);
        check("rst:rd_addr", am_move_index, 0);
        check("rst:clear", am_clear_moves, 1'b0);
        check("rst:list_done", list_done, 1'b0);
        check("rst:status", done_status, 2'b00);
        check("rst:busy", busy, 1'b0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rst:no_clear_after", am_clear_moves, 1'b0);
        end

        // Throughput at RD_LATENCY 1 and 3 with the consumer always ready.
        fill_table();
        lat_count = IW'(5);
        lat_go    = 1'b1;
        tick();
        lat_go    = 1'b0;
        l1_pulses = 0;
        l3_pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (l1_valid) begin
                check("lat1:index", l1_mindex, l1_rise.size());
                check("lat1:uci", l1_uci, t_uci[l1_rise.size()]);
                check("lat1:eval", l1_eval, t_eval[l1_rise.size()]);
                check("lat1:capture", l1_cap, t_cap[l1_rise.size()]);
                check("lat1:last", l1_last, (l1_rise.size() == 4));
                l1_rise.push_back(c);
            end
            if (l3_valid) begin
                check("lat3:index", l3_mindex, l3_rise.size());
                check("lat3:uci", l3_uci, t_uci[l3_rise.size()]);
                check("lat3:eval", l3_eval, t_eval[l3_rise.size()]);
                check("lat3:capture", l3_cap, t_cap[l3_rise.size()]);
                check("lat3:last", l3_last, (l3_rise.size() == 4));
                l3_rise.push_back(c);
            end
            if (l1_clr) l1_pulses++;
            if (l3_clr) l3_pulses++;
            check("lat:done_pairs", {l1_done, l3_done}, {l1_clr, l3_clr});
            tick();
        end
        check("lat1:moves", l1_rise.size(), 5);
        check("lat3:moves", l3_rise.size(), 5);
        if (l1_rise.size() > 0) check("lat1:first", l1_rise[0], 1);
        if (l3_rise.size() > 0) check("lat3:first", l3_rise[0], 3);
        for (int i = 1; i < l1_rise.size(); i++) check("lat1:period", l1_rise[i] - l1_rise[i-1], 2);
        for (int i = 1; i < l3_rise.size(); i++) check("lat3:period", l3_rise[i] - l3_rise[i-1], 4);
        check("lat1:pulses", l1_pulses, 1);
        check("lat3:pulses", l3_pulses, 1);
        check("lat:busy_end", {l1_busy, l3_busy}, 2'b00);
        check("lat:status", {l1_status, l3_status}, 4'b0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
